// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers, MTHI/MTLO writes and busy/done handshake.
// Define MULDIV_ACCUM_EN to enable MADD/MADDU (accumulate product into {HI,LO}).
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  input  logic             ra,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mdc;
  logic [WIDTH-1:0]   a_raw;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, div0, neg_qp, neg_r;
`ifdef MULDIV_ACCUM_EN
  logic               is_acc;
`endif

  logic               op_valid, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  assign rd   = ra ? hi : lo;
  assign busy = (state != IDLE);

  always_comb begin
    op_valid = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: op_valid = 1'b1;
`ifdef MULDIV_ACCUM_EN
      3'b100, 3'b101:                 op_valid = 1'b1;
`endif
      default:                        op_valid = 1'b0;
    endcase
  end

  // Even op codes are the signed variants.
  always_comb begin
    sa    = ~op[0] & a[WIDTH-1];
    sb    = ~op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mdc : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mdc};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg_qp ? -acc : acc;
    quo    = neg_qp ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
`ifdef MULDIV_ACCUM_EN
    else if (is_acc) begin
      {res_hi, res_lo} = {hi, lo} + prod;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mdc    <= '0;
      a_raw  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_qp <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      is_acc <= 1'b0;
`endif
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (we_hi) hi <= wd;
          if (we_lo) lo <= wd;
          if (start && op_valid) begin
            is_div <= op[1];
`ifdef MULDIV_ACCUM_EN
            is_acc <= op[2];
`endif
            neg_qp <= sa ^ sb;
            neg_r  <= sa;
            div0   <= op[1] && (b == '0);
            a_raw  <= a;
            mdc    <= op[1] ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
